// File: rtl/st_arb_pkg.sv
// Shared types and the round-robin pick helper for the packet channel arbiter.
package st_arb_pkg;

    localparam int unsigned MAX_IN    = 8;
    localparam int unsigned MAX_IDX_W = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                 any;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set request bit scanning ptr, ptr+1, ... modulo n.
    function automatic rr_pick_t rr_pick(input logic [MAX_IN-1:0]    req,
                                         input logic [MAX_IDX_W-1:0] ptr,
                                         input int unsigned          n);
        rr_pick_t    r;
        int unsigned j;
        r = '0;
        for (int unsigned off = 0; off < MAX_IN; off++) begin
            if (off < n) begin
                j = (32'(ptr) + off) % n;
                if (!r.any && req[MAX_IDX_W'(j)]) begin
                    r.any = 1'b1;
                    r.idx = MAX_IDX_W'(j);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin priority pick from a request vector and start pointer.
module rr_arbiter_core
    import st_arb_pkg::*;
#(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned IDX_W  = 2
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic              any_o,
    output logic [IDX_W-1:0]  idx_o
);

    rr_pick_t pick_c;

    // Widen to the package helper's fixed width, then narrow the result back.
    always_comb begin
        pick_c = rr_pick(MAX_IN'(req_i), MAX_IDX_W'(ptr_i), NUM_IN);
        any_o  = pick_c.any;
        idx_o  = IDX_W'(pick_c.idx);
    end

endmodule

// File: rtl/st_packet_channel_arbiter.sv
// Packet-granular round-robin merge of NUM_IN byte streams onto one channelized stream.
module st_packet_channel_arbiter
    import st_arb_pkg::*;
#(
    parameter int unsigned NUM_IN    = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CHANNEL_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_startofpacket,
    input  logic [NUM_IN-1:0]        in_endofpacket,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CHANNEL_W-1:0]     out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic                     busy
);

    localparam int unsigned IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    if (CHANNEL_W < IDX_W) begin : g_chk_channel_w
        $error("st_packet_channel_arbiter: CHANNEL_W must be >= IDX_W");
    end
    if ((NUM_IN < 2) || (NUM_IN > MAX_IN)) begin : g_chk_num_in
        $error("st_packet_channel_arbiter: NUM_IN must be 2..8");
    end

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_IN-1:0]  req_c;
    logic               win_any_c;
    logic [IDX_W-1:0]   win_idx_c;

    logic               sel_valid_c;
    logic [DATA_W-1:0]  sel_data_c;
    logic               sel_sop_c;
    logic               sel_eop_c;

    // Only a valid start-of-packet beat may compete for the shared path.
    assign req_c = in_valid & in_startofpacket;

    rr_arbiter_core #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_rr_core (
        .req_i  (req_c),
        .ptr_i  (rr_ptr_q),
        .any_o  (win_any_c),
        .idx_o  (win_idx_c)
    );

    // Select the granted stream's beat.
    always_comb begin
        sel_valid_c = 1'b0;
        sel_data_c  = '0;
        sel_sop_c   = 1'b0;
        sel_eop_c   = 1'b0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            if (grant_idx_q == IDX_W'(i)) begin
                sel_valid_c = in_valid[i];
                sel_data_c  = in_data[i*DATA_W +: DATA_W];
                sel_sop_c   = in_startofpacket[i];
                sel_eop_c   = in_endofpacket[i];
            end
        end
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Arbitrate in IDLE; release the grant once the EOP beat is accepted.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (win_any_c) begin
                    grant_idx_d = win_idx_c;
                    state_d     = LOCKED;
                end
            end
            LOCKED: begin
                if (sel_valid_c && out_ready && sel_eop_c) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_idx_q == IDX_W'(NUM_IN - 1)) ? '0
                                                                   : grant_idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Zero-latency passthrough of the granted stream while locked; quiet otherwise.
    always_comb begin
        in_ready          = '0;
        out_valid         = 1'b0;
        out_data          = '0;
        out_channel       = '0;
        out_startofpacket = 1'b0;
        out_endofpacket   = 1'b0;
        busy              = 1'b0;
        if (state_q == LOCKED) begin
            out_valid         = sel_valid_c;
            out_data          = sel_data_c;
            out_channel       = CHANNEL_W'(grant_idx_q);
            out_startofpacket = sel_sop_c;
            out_endofpacket   = sel_eop_c;
            busy              = 1'b1;
            for (int i = 0; i < int'(NUM_IN); i++) begin
                in_ready[i] = (grant_idx_q == IDX_W'(i)) && out_ready;
            end
        end
    end

endmodule

// File: tb/tb_st_packet_channel_arbiter.sv
// Bench for st_packet_channel_arbiter: directed scenarios plus randomized traffic.
module tb_st_packet_channel_arbiter;

    localparam int NIN = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_startofpacket;
    logic [3:0]  in_endofpacket;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [7:0]  out_channel;
    logic        out_startofpacket;
    logic        out_endofpacket;
    logic        busy;

    always #5 clk = ~clk;

    st_packet_channel_arbiter #(
        .NUM_IN    (4),
        .DATA_W    (8),
        .CHANNEL_W (8)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_channel       (out_channel),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .busy              (busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } beat_t;

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } obeat_t;

    beat_t      sq[NIN][$];
    logic [7:0] sent[NIN][$];
    logic [7:0] recv[NIN][$];
    obeat_t     olog[$];

    // Reference: packet-locked flag, holder, and next-search start.
    bit m_locked;
    int m_g;
    int m_ptr;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input int s, input int len, input logic [7:0] base, input bit incr);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = incr ? base + 8'(k) : 8'($urandom);
            b.sop  = (k == 0);
            b.eop  = (k == len - 1);
            sq[s].push_back(b);
            sent[s].push_back(b.data);
        end
    endtask

    // One clock: drive at negedge, check combinational outputs, advance the reference.
    task automatic step(input logic [3:0] vmask, input logic ordy, input logic rst_val);
        logic [3:0] dv, ds, de, exp_rdy;
        logic [7:0] dd [NIN];
        logic       exp_valid, exp_sop, exp_eop, exp_busy;
        logic [7:0] exp_data, exp_ch;
        bit         found;
        int         idx;
        @(negedge clk);
        reset_n = rst_val;
        for (int i = 0; i < NIN; i++) begin
            if (sq[i].size() > 0 && vmask[i]) begin
                dv[i] = 1'b1;
                dd[i] = sq[i][0].data;
                ds[i] = sq[i][0].sop;
                de[i] = sq[i][0].eop;
            end else begin
                dv[i] = 1'b0;
                dd[i] = 8'($urandom);
                ds[i] = 1'($urandom);
                de[i] = 1'($urandom);
            end
            in_data[i*8 +: 8] = dd[i];
        end
        in_valid         = dv;
        in_startofpacket = ds;
        in_endofpacket   = de;
        out_ready        = ordy;
        #1;
        exp_valid = 1'b0; exp_sop = 1'b0; exp_eop = 1'b0; exp_busy = 1'b0;
        exp_data  = 8'h00; exp_ch = 8'h00; exp_rdy = 4'h0;
        if (!reset_n) begin
            m_locked = 1'b0; m_g = 0; m_ptr = 0;
        end else if (m_locked) begin
            exp_valid = dv[m_g];
            exp_data  = dd[m_g];
            exp_sop   = ds[m_g];
            exp_eop   = de[m_g];
            exp_ch    = 8'(m_g);
            exp_rdy   = 4'(ordy) << m_g;
            exp_busy  = 1'b1;
        end
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("out_data",  32'(out_data),  32'(exp_data));
        chk("out_sop",   32'(out_startofpacket), 32'(exp_sop));
        chk("out_eop",   32'(out_endofpacket),   32'(exp_eop));
        chk("out_channel", 32'(out_channel), 32'(exp_ch));
        chk("in_ready",  32'(in_ready), 32'(exp_rdy));
        chk("busy",      32'(busy), 32'(exp_busy));
        if (out_valid && out_ready) begin
            olog.push_back('{int'(out_channel), out_data, out_startofpacket, out_endofpacket});
            if (out_channel < 8'(NIN)) recv[int'(out_channel)].push_back(out_data);
        end
        for (int i = 0; i < NIN; i++)
            if (exp_rdy[i] && dv[i]) void'(sq[i].pop_front());
        if (reset_n) begin
            if (m_locked) begin
                if (dv[m_g] && ordy && de[m_g]) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_g + 1) % NIN;
                end
            end else begin
                found = 1'b0;
                for (int k = 0; k < NIN; k++) begin
                    idx = (m_ptr + k) % NIN;
                    if (!found && dv[idx] && ds[idx]) begin
                        found = 1'b1; m_locked = 1'b1; m_g = idx;
                    end
                end
            end
        end
    endtask

    task automatic chk_beat(input string tag, input int n, input int ch, input logic [7:0] d,
                            input logic sop, input logic eop);
        obeat_t b;
        b = '{-1, 8'h00, 1'b0, 1'b0};
        if (n < olog.size()) b = olog[n];
        chk({tag, "_ch"},   32'(b.ch),   32'(ch));
        chk({tag, "_data"}, 32'(b.data), 32'(d));
        chk({tag, "_sop"},  32'(b.sop),  32'(sop));
        chk({tag, "_eop"},  32'(b.eop),  32'(eop));
    endtask

    initial begin
        int left;
        int guard;
        reset_n = 1'b0; in_valid = '0; in_data = '0; in_startofpacket = '0;
        in_endofpacket = '0; out_ready = 1'b0;
        m_locked = 1'b0; m_g = 0; m_ptr = 0;

        // Reset values.
        step(4'hF, 1'b1, 1'b0);
        step(4'hF, 1'b1, 1'b0);

        // Stream 2 four-beat packet A0..A3.
        olog.delete();
        push_pkt(2, 4, 8'hA0, 1'b1);
        for (int c = 0; c < 6; c++) step(4'hF, 1'b1, 1'b1);
        chk("p2_len", 32'(olog.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            chk_beat("p2_beat", k, 2, 8'hA0 + 8'(k), k == 0, k == 3);

        // Pointer now 3: streams 0 and 3 contend, 3 goes first.
        olog.delete();
        push_pkt(0, 1, 8'h10, 1'b1);
        push_pkt(3, 1, 8'h30, 1'b1);
        for (int c = 0; c < 5; c++) step(4'hF, 1'b1, 1'b1);
        chk_beat("ptr3_first", 0, 3, 8'h30, 1'b1, 1'b1);
        chk_beat("ptr3_second", 1, 0, 8'h10, 1'b1, 1'b1);

        // All four request from reset: order 0,1,2,3,0.
        step(4'h0, 1'b1, 1'b0);
        olog.delete();
        push_pkt(0, 2, 8'h00, 1'b1);
        push_pkt(1, 2, 8'h10, 1'b1);
        push_pkt(2, 2, 8'h20, 1'b1);
        push_pkt(3, 2, 8'h30, 1'b1);
        push_pkt(0, 2, 8'h40, 1'b1);
        for (int c = 0; c < 17; c++) step(4'hF, 1'b1, 1'b1);
        chk("all4_len", 32'(olog.size()), 32'd10);
        for (int k = 0; k < 10; k++)
            chk_beat("all4", k, (k / 2) % 4, 8'(16 * (k / 2) + (k % 2)), (k % 2) == 0, (k % 2) == 1);

        // Stream 1 with out_ready toggling.
        olog.delete();
        push_pkt(1, 4, 8'hB0, 1'b1);
        step(4'hF, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) step(4'hF, (k % 2) == 0, 1'b1);
        chk("toggle_len", 32'(olog.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            chk_beat("toggle", k, 1, 8'hB0 + 8'(k), k == 0, k == 3);

        // Valid without SOP while idle is not a request.
        olog.delete();
        sq[3].push_back('{8'h77, 1'b0, 1'b0});
        for (int c = 0; c < 3; c++) step(4'hF, 1'b1, 1'b1);
        chk("nosop_len", 32'(olog.size()), 32'd0);
        sq[3].delete();

        // Single-beat stream 3 packet, then pointer wraps to 0.
        olog.delete();
        push_pkt(3, 1, 8'h5C, 1'b1);
        for (int c = 0; c < 3; c++) step(4'hF, 1'b1, 1'b1);
        push_pkt(0, 1, 8'h01, 1'b1);
        push_pkt(2, 1, 8'h02, 1'b1);
        for (int c = 0; c < 5; c++) step(4'hF, 1'b1, 1'b1);
        chk_beat("single", 0, 3, 8'h5C, 1'b1, 1'b1);
        chk_beat("wrap_first", 1, 0, 8'h01, 1'b1, 1'b1);
        chk_beat("wrap_second", 2, 2, 8'h02, 1'b1, 1'b1);

        // Reset in the middle of a stream 0 packet.
        olog.delete();
        push_pkt(0, 4, 8'hC0, 1'b1);
        step(4'hF, 1'b1, 1'b1);
        step(4'hF, 1'b1, 1'b1);
        step(4'hF, 1'b1, 1'b0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        step(4'hF, 1'b1, 1'b0);
        sq[0].delete();
        step(4'hF, 1'b1, 1'b1);
        push_pkt(1, 2, 8'hD0, 1'b1);
        for (int c = 0; c < 4; c++) step(4'hF, 1'b1, 1'b1);
        chk("rst_len", 32'(olog.size()), 32'd3);
        chk_beat("rst_pre", 0, 0, 8'hC0, 1'b1, 1'b0);
        chk_beat("rst_post0", 1, 1, 8'hD0, 1'b1, 1'b0);
        chk_beat("rst_post1", 2, 1, 8'hD1, 1'b0, 1'b1);

        // Randomized traffic with per-stream content scoreboard.
        for (int i = 0; i < NIN; i++) begin
            sent[i].delete();
            recv[i].delete();
        end
        for (int i = 0; i < NIN; i++)
            for (int p = 0; p < 6; p++)
                push_pkt(i, int'($urandom_range(1, 4)), 8'h00, 1'b0);
        for (int c = 0; c < 600; c++)
            step(4'($urandom), $urandom_range(0, 3) != 0, 1'b1);
        guard = 0;
        left  = 1;
        while (left != 0 && guard < 500) begin
            step(4'hF, 1'b1, 1'b1);
            guard++;
            left = 0;
            for (int i = 0; i < NIN; i++) left += sq[i].size();
        end
        chk("drain_remaining", 32'(left), 32'd0);
        for (int i = 0; i < NIN; i++) begin
            chk("rand_count", 32'(recv[i].size()), 32'(sent[i].size()));
            for (int k = 0; k < sent[i].size(); k++) begin
                if (k < recv[i].size()) chk("rand_data", 32'(recv[i][k]), 32'(sent[i][k]));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/st_packet_channel_arbiter.md
Name: st_packet_channel_arbiter

Overview:
- Round-robin, packet-granular arbiter that merges NUM_IN independent Avalon-ST byte packet streams onto one channelized Avalon-ST stream.
- Output feeds the HPS-only master's bytes-to-packets channel adapter input.
- Output channel = index of the granted requester.
- Grant is held from startofpacket through the accepted endofpacket beat, so packets never interleave on the shared path.

Parameters:
- NUM_IN, 4: number of requesting streams, 2..8.
- DATA_W, 8: symbol/data width per stream.
- CHANNEL_W, 8: output channel width; index zero-extended.
- IDX_W, $clog2(NUM_IN): derived; internal grant index width.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  NUM_IN  per-stream valid; bit i = stream i.
- in_ready  out  NUM_IN  per-stream ready.
- in_data  in  NUM_IN*DATA_W  stream i at [i*DATA_W +: DATA_W].
- in_startofpacket  in  NUM_IN  per-stream SOP.
- in_endofpacket  in  NUM_IN  per-stream EOP.
- out_ready  in  1  downstream ready.
- out_valid  out  1  merged valid.
- out_data  out  DATA_W  merged data.
- out_channel  out  CHANNEL_W  granted stream index.
- out_startofpacket  out  1  merged SOP.
- out_endofpacket  out  1  merged EOP.
- busy  out  1  high while in LOCKED.

Behaviour:
- State and reset:
  - Registered state: fsm {IDLE, LOCKED}, grant_idx[IDX_W], rr_ptr[IDX_W].
  - reset_n low, asynchronously: fsm=IDLE, grant_idx=0, rr_ptr=0.
  - While in reset: in_ready=0, out_valid=0, out_sop=0, out_eop=0, out_data=0, out_channel=0, busy=0.
- IDLE:
  - All in_ready=0, out_valid=0, busy=0.
  - out_data, out_channel, out_sop and out_eop driven 0.
  - A request is in_valid[i] & in_startofpacket[i].
  - Winner = first request scanning rr_ptr, rr_ptr+1, ... mod NUM_IN.
  - If any request: grant_idx<=winner, fsm<=LOCKED. Otherwise stay in IDLE.
  - Valid beats without SOP are not requests; they stall with in_ready=0.
- LOCKED (g = grant_idx):
  - Zero-latency passthrough: out_valid=in_valid[g], out_data=in_data[g], out_sop=in_startofpacket[g], out_eop=in_endofpacket[g].
  - out_channel=g zero-extended; in_ready[g]=out_ready; all other in_ready=0; busy=1.
  - On an accepted beat (in_valid[g] & out_ready) with in_endofpacket[g]=1: fsm<=IDLE, rr_ptr<=(g==NUM_IN-1)?0:g+1.
  - Otherwise hold state. in_valid[g] low mid-packet simply stalls; the grant is held indefinitely.
- Latency:
  - 1 cycle from request to first output beat (the IDLE arbitration cycle).
  - Exactly one idle bubble between back-to-back packets.
  - No data buffering; out_valid never asserted without in_valid[g].
- Boundary cases:
  - Single-beat packet (SOP=EOP=1): LOCKED for one accepted cycle, then IDLE.
  - A mid-packet SOP on the granted stream is passed through; the grant is not re-arbitrated.
  - rr_ptr wraps NUM_IN-1 -> 0.
  - Only one requester: it wins every time regardless of rr_ptr.
  - out_ready low on the EOP beat: remain LOCKED until accepted.
  - Reset asserted mid-packet: immediate return to reset values; no partial-packet recovery.
- Width rule: out_channel = {(CHANNEL_W-IDX_W)'0, grant_idx}. CHANNEL_W >= IDX_W is required, checked by an elaboration-time assertion.

Decomposition:
- Shared package st_arb_pkg:
  - Enum arb_state_t {IDLE, LOCKED}.
  - Function rr_pick(req, ptr) returning winner index and any-valid.
- Sub-module rr_arbiter_core: combinational round-robin priority pick from request vector and rr_ptr.
- The top holds the FSM, registers and the datapath mux.

Test Plan:
- Stream 2 sends a 4-beat packet 0xA0..0xA3, out_ready=1 -> one IDLE cycle, then 4 beats with out_channel=2, SOP on 0xA0, EOP on 0xA3; rr_ptr=3 afterwards.
- All 4 streams request together from reset -> packets granted in order ch0, ch1, ch2, ch3, ch0, with one bubble between each; no beat interleaving.
- Granted stream 1 packet with out_ready toggling 1,0,1,0 -> in_ready[1] mirrors out_ready; data is neither duplicated nor dropped; EOP held until accepted.
- Stream 3 presents valid without SOP while idle -> in_ready[3]=0, out_valid=0, fsm stays IDLE.
- Stream 3 single-beat packet (SOP=EOP=1, data 0x5C) -> one output beat with channel=3; rr_ptr wraps to 0.
- reset_n dropped on beat 2 of a stream 0 packet -> all outputs 0 the same cycle. After release, a new stream 1 request is granted as ch1.
